ex2mem_stage: RTL

- EX stage plus EX/MEM pipeline register.
- Consumes the registered ID/EX bundle (EXE_CMD, val1, val2, ST_value, dest, memory/writeback enables) and executes the ALU operation.
- Registers the result and controls toward the MEM stage.
- Multiply runs as a multi-cycle shift-add FSM. While it runs, stall freezes the upstream IF/ID and ID/EX registers.

---
 rtl/ex2mem_stage_if.sv | 40 ++++
 rtl/ex2mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ex2mem_stage_if.sv
// ID/EX -> EX/MEM bundle between the upstream pipeline and the EX stage.
interface ex2mem_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    // Upstream side: ID/EX register contents plus flush
    logic                  flush;
    logic                  in_valid;
    logic [3:0]            EXE_CMD_IN;
    logic [DATA_WIDTH-1:0] val1_in;
    logic [DATA_WIDTH-1:0] val2_in;
    logic [DATA_WIDTH-1:0] ST_value_in;
    logic [4:0]            dest_in;
    logic                  MEM_R_EN_IN;
    logic                  MEM_W_EN_IN;
    logic                  WB_EN_IN;

    // EX side: hold request plus EX/MEM register contents
    logic                  stall;
    logic [DATA_WIDTH-1:0] ALU_result;
    logic [DATA_WIDTH-1:0] ST_value;
    logic [4:0]            dest;
    logic                  MEM_R_EN;
    logic                  MEM_W_EN;
    logic                  WB_EN;
    logic                  valid_out;

    modport master (
        output flush, in_valid, EXE_CMD_IN, val1_in, val2_in, ST_value_in,
               dest_in, MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN,
        input  stall, ALU_result, ST_value, dest, MEM_R_EN, MEM_W_EN,
               WB_EN, valid_out
    );

    modport slave (
        input  flush, in_valid, EXE_CMD_IN, val1_in, val2_in, ST_value_in,
               dest_in, MEM_R_EN_IN, MEM_W_EN_IN, WB_EN_IN,
        output stall, ALU_result, ST_value, dest, MEM_R_EN, MEM_W_EN,
               WB_EN, valid_out
    );
endinterface

// File: rtl/ex2mem_stage.sv
// EX stage with EX/MEM pipeline register; multiply is an iterative shift-add.
module ex2mem_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex2mem_stage_if.slave bus
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [3:0] CMD_ADD = 4'd0;
    localparam logic [3:0] CMD_SUB = 4'd1;
    localparam logic [3:0] CMD_AND = 4'd2;
    localparam logic [3:0] CMD_OR  = 4'd3;
    localparam logic [3:0] CMD_NOR = 4'd4;
    localparam logic [3:0] CMD_XOR = 4'd5;
    localparam logic [3:0] CMD_SLL = 4'd6;
    localparam logic [3:0] CMD_SRL = 4'd7;
    localparam logic [3:0] CMD_SRA = 4'd8;
    localparam logic [3:0] CMD_SLT = 4'd9;
    localparam logic [3:0] CMD_MUL = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mcand, mcand_nxt;
    logic [DATA_WIDTH-1:0] mplier, mplier_nxt;
    logic [DATA_WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;

    logic [DATA_WIDTH-1:0] result_q, result_nxt;
    logic [DATA_WIDTH-1:0] st_q, st_nxt;
    logic [4:0]            dest_q, dest_nxt;
    logic                  mr_q, mr_nxt;
    logic                  mw_q, mw_nxt;
    logic                  wb_q, wb_nxt;
    logic                  valid_q, valid_nxt;

    logic [DATA_WIDTH-1:0] alu_c;
    logic [4:0]            shamt;
    logic                  is_mul;
    logic                  stall_c;

    assign shamt  = bus.val2_in[4:0];
    assign is_mul = bus.in_valid && (bus.EXE_CMD_IN == CMD_MUL);

    // Single-cycle ALU; MUL and unused codes yield 0 here
    always_comb begin
        alu_c = '0;
        case (bus.EXE_CMD_IN)
            CMD_ADD: alu_c = bus.val1_in + bus.val2_in;
            CMD_SUB: alu_c = bus.val1_in - bus.val2_in;
            CMD_AND: alu_c = bus.val1_in & bus.val2_in;
            CMD_OR:  alu_c = bus.val1_in | bus.val2_in;
            CMD_NOR: alu_c = ~(bus.val1_in | bus.val2_in);
            CMD_XOR: alu_c = bus.val1_in ^ bus.val2_in;
            CMD_SLL: alu_c = bus.val1_in << shamt;
            CMD_SRL: alu_c = bus.val1_in >> shamt;
            CMD_SRA: alu_c = DATA_WIDTH'($signed(bus.val1_in) >>> shamt);
            CMD_SLT: alu_c = DATA_WIDTH'($signed(bus.val1_in) < $signed(bus.val2_in));
            default: alu_c = '0;
        endcase
    end

    // Next state, multiply datapath and EX/MEM load values; bubble by default
    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        result_nxt = '0;
        st_nxt     = '0;
        dest_nxt   = '0;
        mr_nxt     = 1'b0;
        mw_nxt     = 1'b0;
        wb_nxt     = 1'b0;
        valid_nxt  = 1'b0;
        stall_c    = 1'b0;

        if (bus.flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        stall_c    = 1'b1;
                        mcand_nxt  = bus.val1_in;
                        mplier_nxt = bus.val2_in;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        state_nxt  = BUSY;
                    end else if (bus.in_valid) begin
                        result_nxt = alu_c;
                        st_nxt     = bus.ST_value_in;
                        dest_nxt   = bus.dest_in;
                        mr_nxt     = bus.MEM_R_EN_IN;
                        mw_nxt     = bus.MEM_W_EN_IN;
                        wb_nxt     = bus.WB_EN_IN;
                        valid_nxt  = 1'b1;
                    end
                end
                BUSY: begin
                    stall_c = 1'b1;
                    if (mplier[0]) begin
                        acc_nxt = acc + mcand;
                    end
                    mcand_nxt  = mcand << 1;
                    mplier_nxt = mplier >> 1;
                    cnt_nxt    = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    // Upstream still holds the MUL bundle; pair it with the product
                    result_nxt = acc;
                    st_nxt     = bus.ST_value_in;
                    dest_nxt   = bus.dest_in;
                    mr_nxt     = bus.MEM_R_EN_IN;
                    mw_nxt     = bus.MEM_W_EN_IN;
                    wb_nxt     = bus.WB_EN_IN;
                    valid_nxt  = 1'b1;
                    state_nxt  = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Multiply working registers and EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            st_q     <= '0;
            dest_q   <= '0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            wb_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            mcand    <= mcand_nxt;
            mplier   <= mplier_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            result_q <= result_nxt;
            st_q     <= st_nxt;
            dest_q   <= dest_nxt;
            mr_q     <= mr_nxt;
            mw_q     <= mw_nxt;
            wb_q     <= wb_nxt;
            valid_q  <= valid_nxt;
        end
    end

    // Stall is forced low while reset is held
    assign bus.stall      = stall_c & rst;
    assign bus.ALU_result = result_q;
    assign bus.ST_value   = st_q;
    assign bus.dest       = dest_q;
    assign bus.MEM_R_EN   = mr_q;
    assign bus.MEM_W_EN   = mw_q;
    assign bus.WB_EN      = wb_q;
    assign bus.valid_out  = valid_q;
endmodule
